// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with a load-use hazard detector.
//   Registers the decoded control bundle, operands and specifiers for EX.
//   Inserts a one-cycle bubble on a load-use hazard and requests a stall of
//   PC and IF/ID. Squashes the ID instruction on a branch/jump redirect.
// Optional feature: define ID_EX_STATS_EN to build saturating bubble counters.
//   When it is undefined, stat_lu_o and stat_fl_o are tied to 0.
// Ports:
//   clk, reset          clock; asynchronous active-high reset
//   hold_i              global freeze: all state keeps its value
//   flush_i             redirect: squash the ID instruction
//   id_*_i              decoded instruction fields from ID
//   id_uses_rt_i        the ID instruction reads rt
//   stall_o             combinational: hold PC and IF/ID this cycle
//   ex_*_o              registered copy of the id_*_i fields, plus ex_valid_o
//   stat_lu_o/stat_fl_o load-use and flush bubble counts
module id_ex_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned REG_AW = 5,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hold_i,
    input  logic              flush_i,
    input  logic              id_valid_i,
    input  logic              id_reg_dst_i,
    input  logic              id_alu_src_i,
    input  logic              id_mem_read_i,
    input  logic              id_mem_write_i,
    input  logic              id_mem_to_reg_i,
    input  logic              id_reg_write_i,
    input  logic              id_branch_i,
    input  logic [1:0]        id_alu_op_i,
    input  logic [DATA_W-1:0] id_pc4_i,
    input  logic [DATA_W-1:0] id_rs_data_i,
    input  logic [DATA_W-1:0] id_rt_data_i,
    input  logic [DATA_W-1:0] id_imm_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic [5:0]        id_funct_i,
    input  logic              id_uses_rt_i,
    output logic              stall_o,
    output logic              ex_valid_o,
    output logic              ex_reg_dst_o,
    output logic              ex_alu_src_o,
    output logic              ex_mem_read_o,
    output logic              ex_mem_write_o,
    output logic              ex_mem_to_reg_o,
    output logic              ex_reg_write_o,
    output logic              ex_branch_o,
    output logic [1:0]        ex_alu_op_o,
    output logic [DATA_W-1:0] ex_pc4_o,
    output logic [DATA_W-1:0] ex_rs_data_o,
    output logic [DATA_W-1:0] ex_rt_data_o,
    output logic [DATA_W-1:0] ex_imm_o,
    output logic [REG_AW-1:0] ex_rs_o,
    output logic [REG_AW-1:0] ex_rt_o,
    output logic [REG_AW-1:0] ex_rd_o,
    output logic [5:0]        ex_funct_o,
    output logic [CNT_W-1:0]  stat_lu_o,
    output logic [CNT_W-1:0]  stat_fl_o
);

    logic lu_c;
    logic bubble_c;

    // Load in EX whose destination feeds the instruction in ID; $0 never hazards.
    always_comb begin
        lu_c = ex_valid_o & ex_mem_read_o & (ex_rt_o != '0) & id_valid_i &
               ((ex_rt_o == id_rs_i) | (id_uses_rt_i & (ex_rt_o == id_rt_i)));
        bubble_c = flush_i | lu_c;
    end

    // A redirect discards the ID instruction, so upstream must not be frozen.
    assign stall_o = lu_c & ~flush_i;

    // Pipeline register; a bubble is all-zero, i.e. an invalid SLL $0,$0,0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_valid_o      <= 1'b0;
            ex_reg_dst_o    <= 1'b0;
            ex_alu_src_o    <= 1'b0;
            ex_mem_read_o   <= 1'b0;
            ex_mem_write_o  <= 1'b0;
            ex_mem_to_reg_o <= 1'b0;
            ex_reg_write_o  <= 1'b0;
            ex_branch_o     <= 1'b0;
            ex_alu_op_o     <= '0;
            ex_pc4_o        <= '0;
            ex_rs_data_o    <= '0;
            ex_rt_data_o    <= '0;
            ex_imm_o        <= '0;
            ex_rs_o         <= '0;
            ex_rt_o         <= '0;
            ex_rd_o         <= '0;
            ex_funct_o      <= '0;
        end else if (!hold_i) begin
            if (bubble_c) begin
                ex_valid_o      <= 1'b0;
                ex_reg_dst_o    <= 1'b0;
                ex_alu_src_o    <= 1'b0;
                ex_mem_read_o   <= 1'b0;
                ex_mem_write_o  <= 1'b0;
                ex_mem_to_reg_o <= 1'b0;
                ex_reg_write_o  <= 1'b0;
                ex_branch_o     <= 1'b0;
                ex_alu_op_o     <= '0;
                ex_pc4_o        <= '0;
                ex_rs_data_o    <= '0;
                ex_rt_data_o    <= '0;
                ex_imm_o        <= '0;
                ex_rs_o         <= '0;
                ex_rt_o         <= '0;
                ex_rd_o         <= '0;
                ex_funct_o      <= '0;
            end else begin
                ex_valid_o      <= id_valid_i;
                ex_reg_dst_o    <= id_reg_dst_i;
                ex_alu_src_o    <= id_alu_src_i;
                ex_mem_read_o   <= id_mem_read_i;
                ex_mem_write_o  <= id_mem_write_i;
                ex_mem_to_reg_o <= id_mem_to_reg_i;
                ex_reg_write_o  <= id_reg_write_i;
                ex_branch_o     <= id_branch_i;
                ex_alu_op_o     <= id_alu_op_i;
                ex_pc4_o        <= id_pc4_i;
                ex_rs_data_o    <= id_rs_data_i;
                ex_rt_data_o    <= id_rt_data_i;
                ex_imm_o        <= id_imm_i;
                ex_rs_o         <= id_rs_i;
                ex_rt_o         <= id_rt_i;
                ex_rd_o         <= id_rd_i;
                ex_funct_o      <= id_funct_i;
            end
        end
    end

`ifdef ID_EX_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Saturating bubble counters; flush takes precedence over load-use.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_lu_o <= '0;
            stat_fl_o <= '0;
        end else if (!hold_i) begin
            if (flush_i) begin
                if (stat_fl_o != CNT_MAX) stat_fl_o <= stat_fl_o + CNT_W'(1);
            end else if (lu_c) begin
                if (stat_lu_o != CNT_MAX) stat_lu_o <= stat_lu_o + CNT_W'(1);
            end
        end
    end
`else
    assign stat_lu_o = '0;
    assign stat_fl_o = '0;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
module tb_id_ex_stage;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned CNT_W  = 16;
`ifdef ID_EX_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset, hold_i, flush_i;
    logic id_valid_i, id_reg_dst_i, id_alu_src_i, id_mem_read_i, id_mem_write_i;
    logic id_mem_to_reg_i, id_reg_write_i, id_branch_i, id_uses_rt_i;
    logic [1:0] id_alu_op_i;
    logic [DATA_W-1:0] id_pc4_i, id_rs_data_i, id_rt_data_i, id_imm_i;
    logic [REG_AW-1:0] id_rs_i, id_rt_i, id_rd_i;
    logic [5:0] id_funct_i;
    logic stall_o, ex_valid_o, ex_reg_dst_o, ex_alu_src_o, ex_mem_read_o, ex_mem_write_o;
    logic ex_mem_to_reg_o, ex_reg_write_o, ex_branch_o;
    logic [1:0] ex_alu_op_o;
    logic [DATA_W-1:0] ex_pc4_o, ex_rs_data_o, ex_rt_data_o, ex_imm_o;
    logic [REG_AW-1:0] ex_rs_o, ex_rt_o, ex_rd_o;
    logic [5:0] ex_funct_o;
    logic [CNT_W-1:0] stat_lu_o, stat_fl_o;

    int total = 0;
    int bad = 0;
    logic [CNT_W-1:0] exp_lu = '0;
    logic [CNT_W-1:0] exp_fl = '0;

    always #5 clk = ~clk;

    id_ex_stage #(.DATA_W(DATA_W), .REG_AW(REG_AW), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .hold_i(hold_i), .flush_i(flush_i),
        .id_valid_i(id_valid_i), .id_reg_dst_i(id_reg_dst_i), .id_alu_src_i(id_alu_src_i),
        .id_mem_read_i(id_mem_read_i), .id_mem_write_i(id_mem_write_i),
        .id_mem_to_reg_i(id_mem_to_reg_i), .id_reg_write_i(id_reg_write_i),
        .id_branch_i(id_branch_i), .id_alu_op_i(id_alu_op_i), .id_pc4_i(id_pc4_i),
        .id_rs_data_i(id_rs_data_i), .id_rt_data_i(id_rt_data_i), .id_imm_i(id_imm_i),
        .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_rd_i(id_rd_i), .id_funct_i(id_funct_i),
        .id_uses_rt_i(id_uses_rt_i), .stall_o(stall_o), .ex_valid_o(ex_valid_o),
        .ex_reg_dst_o(ex_reg_dst_o), .ex_alu_src_o(ex_alu_src_o),
        .ex_mem_read_o(ex_mem_read_o), .ex_mem_write_o(ex_mem_write_o),
        .ex_mem_to_reg_o(ex_mem_to_reg_o), .ex_reg_write_o(ex_reg_write_o),
        .ex_branch_o(ex_branch_o), .ex_alu_op_o(ex_alu_op_o), .ex_pc4_o(ex_pc4_o),
        .ex_rs_data_o(ex_rs_data_o), .ex_rt_data_o(ex_rt_data_o), .ex_imm_o(ex_imm_o),
        .ex_rs_o(ex_rs_o), .ex_rt_o(ex_rt_o), .ex_rd_o(ex_rd_o), .ex_funct_o(ex_funct_o),
        .stat_lu_o(stat_lu_o), .stat_fl_o(stat_fl_o)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic rdst, input logic asrc, input logic mrd,
                          input logic mwr, input logic m2r, input logic rwr, input logic br,
                          input logic [1:0] aop, input logic [31:0] imm,
                          input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input logic [5:0] fn, input logic urt);
        id_valid_i = v; id_reg_dst_i = rdst; id_alu_src_i = asrc; id_mem_read_i = mrd;
        id_mem_write_i = mwr; id_mem_to_reg_i = m2r; id_reg_write_i = rwr; id_branch_i = br;
        id_alu_op_i = aop; id_imm_i = imm; id_rs_i = rs; id_rt_i = rt; id_rd_i = rd;
        id_funct_i = fn; id_uses_rt_i = urt;
        id_pc4_i = 32'h0000_1000 + {27'd0, rs} * 4;
        id_rs_data_i = 32'hA000_0000 | {27'd0, rs};
        id_rt_data_i = 32'hB000_0000 | {27'd0, rt};
    endtask

    task automatic id_lw(input logic v, input logic [4:0] rt, input logic [4:0] rs);
        set_id(v, 0, 1, 1, 0, 1, 1, 0, 2'd0, 32'd0, rs, rt, 5'd0, 6'd0, 1'b0);
    endtask
    task automatic id_add(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
        set_id(1, 1, 0, 0, 0, 0, 1, 0, 2'd2, 32'd0, rs, rt, rd, 6'h20, 1'b1);
    endtask
    task automatic id_addi(input logic [4:0] rt, input logic [4:0] rs, input logic [31:0] imm);
        set_id(1, 0, 1, 0, 0, 0, 1, 0, 2'd0, imm, rs, rt, 5'd0, 6'd0, 1'b0);
    endtask

    task automatic test_reset();
        reset = 1; hold_i = 0; flush_i = 0;
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 2'd0, 32'd0, 5'd0, 5'd0, 5'd0, 6'd0, 1'b0);
        tick(); tick();
        reset = 0;
        #1;
        total++;
        if ({ex_valid_o, ex_reg_write_o, ex_mem_read_o, ex_alu_src_o, ex_alu_op_o} !== 6'd0 ||
            ex_imm_o !== 32'd0 || ex_rt_o !== 5'd0 || ex_pc4_o !== 32'd0) begin
            bad++; $display("FAIL reset_state valid=%b imm=%h rt=%0d", ex_valid_o, ex_imm_o, ex_rt_o);
        end
        total++;
        if (stall_o !== 1'b0 || stat_lu_o !== '0 || stat_fl_o !== '0) begin
            bad++; $display("FAIL reset_stall_stats stall=%b lu=%0d fl=%0d", stall_o, stat_lu_o, stat_fl_o);
        end
        id_addi(5'd2, 5'd1, 32'd5);
        tick();
        total++;
        if (ex_reg_write_o !== 1'b1 || ex_alu_src_o !== 1'b1 || ex_imm_o !== 32'd5 ||
            ex_rt_o !== 5'd2 || ex_rs_o !== 5'd1 || ex_valid_o !== 1'b1 ||
            ex_pc4_o !== 32'h0000_1004 || ex_rs_data_o !== 32'hA000_0001) begin
            bad++; $display("FAIL addi_latch rw=%b as=%b imm=%h rt=%0d pc4=%h want 1 1 5 2 1004",
                            ex_reg_write_o, ex_alu_src_o, ex_imm_o, ex_rt_o, ex_pc4_o);
        end
    endtask

    task automatic test_load_use();
        id_lw(1, 5'd3, 5'd1);
        tick();
        id_add(5'd4, 5'd3, 5'd5);
        #1;
        total++;
        if (stall_o !== 1'b1) begin bad++; $display("FAIL lu_rs_stall got=%b want=1", stall_o); end
        tick();
        exp_lu++;
        total++;
        if (ex_valid_o !== 1'b0 || ex_mem_read_o !== 1'b0 || ex_rt_o !== 5'd0 || stall_o !== 1'b0) begin
            bad++; $display("FAIL lu_bubble valid=%b mr=%b rt=%0d stall=%b want 0 0 0 0",
                            ex_valid_o, ex_mem_read_o, ex_rt_o, stall_o);
        end
        tick();
        total++;
        if (ex_valid_o !== 1'b1 || ex_rd_o !== 5'd4 || ex_rs_o !== 5'd3 || ex_reg_dst_o !== 1'b1 ||
            ex_funct_o !== 6'h20 || ex_alu_op_o !== 2'd2) begin
            bad++; $display("FAIL lu_after valid=%b rd=%0d rs=%0d funct=%h", ex_valid_o, ex_rd_o, ex_rs_o, ex_funct_o);
        end
        total++;
        if (stat_lu_o !== (STATS ? exp_lu : '0)) begin
            bad++; $display("FAIL lu_count got=%0d want=%0d", stat_lu_o, STATS ? exp_lu : '0);
        end
        // hazard via rt, gated by uses_rt
        id_lw(1, 5'd7, 5'd2);
        tick();
        id_add(5'd8, 5'd1, 5'd7);
        #1;
        total++;
        if (stall_o !== 1'b1) begin bad++; $display("FAIL lu_rt_stall got=%b want=1", stall_o); end
        id_uses_rt_i = 1'b0;
        #1;
        total++;
        if (stall_o !== 1'b0) begin bad++; $display("FAIL lu_rt_unused got=%b want=0", stall_o); end
        id_uses_rt_i = 1'b1;
        tick();
        exp_lu++;
        tick();
        total++;
        if (ex_valid_o !== 1'b1 || ex_rd_o !== 5'd8 || ex_rt_o !== 5'd7) begin
            bad++; $display("FAIL lu_rt_after valid=%b rd=%0d rt=%0d", ex_valid_o, ex_rd_o, ex_rt_o);
        end
    endtask

    task automatic test_specifiers();
        id_lw(1, 5'd3, 5'd1);
        tick();
        id_addi(5'd3, 5'd3, 32'd1);
        #1;
        total++;
        if (stall_o !== 1'b1) begin bad++; $display("FAIL spec_addi_rs got=%b want=1", stall_o); end
        set_id(1, 0, 1, 0, 0, 0, 1, 0, 2'd3, 32'd1, 5'd6, 5'd3, 5'd0, 6'd0, 1'b0);
        #1;
        total++;
        if (stall_o !== 1'b0) begin bad++; $display("FAIL spec_ori_nostall got=%b want=0", stall_o); end
        id_add(5'd4, 5'd3, 5'd3);
        id_valid_i = 1'b0;
        #1;
        total++;
        if (stall_o !== 1'b0) begin bad++; $display("FAIL spec_id_invalid got=%b want=0", stall_o); end
        tick();
        total++;
        if (ex_valid_o !== 1'b0 || ex_rs_o !== 5'd3 || ex_rd_o !== 5'd4) begin
            bad++; $display("FAIL spec_invalid_reg valid=%b rs=%0d rd=%0d want 0 3 4", ex_valid_o, ex_rs_o, ex_rd_o);
        end
        id_lw(1, 5'd0, 5'd1);
        tick();
        id_add(5'd4, 5'd0, 5'd0);
        #1;
        total++;
        if (stall_o !== 1'b0) begin bad++; $display("FAIL spec_lw_r0 got=%b want=0", stall_o); end
        id_lw(0, 5'd3, 5'd1);
        tick();
        id_add(5'd4, 5'd3, 5'd5);
        #1;
        total++;
        if (stall_o !== 1'b0 || ex_mem_read_o !== 1'b1) begin
            bad++; $display("FAIL spec_ex_invalid stall=%b mr=%b want 0 1", stall_o, ex_mem_read_o);
        end
        tick();
    endtask

    task automatic test_flush();
        id_lw(1, 5'd3, 5'd1);
        tick();
        id_add(5'd4, 5'd3, 5'd5);
        flush_i = 1'b1;
        #1;
        total++;
        if (stall_o !== 1'b0) begin bad++; $display("FAIL flush_masks_stall got=%b want=0", stall_o); end
        tick();
        exp_fl++;
        flush_i = 1'b0;
        total++;
        if (ex_valid_o !== 1'b0 || ex_rd_o !== 5'd0 || ex_reg_write_o !== 1'b0 || ex_pc4_o !== 32'd0) begin
            bad++; $display("FAIL flush_bubble valid=%b rd=%0d rw=%b", ex_valid_o, ex_rd_o, ex_reg_write_o);
        end
        total++;
        if (stat_fl_o !== (STATS ? exp_fl : '0) || stat_lu_o !== (STATS ? exp_lu : '0)) begin
            bad++; $display("FAIL flush_counts fl=%0d lu=%0d want %0d %0d", stat_fl_o, stat_lu_o,
                            STATS ? exp_fl : '0, STATS ? exp_lu : '0);
        end
        tick();
        total++;
        if (ex_valid_o !== 1'b1 || ex_rd_o !== 5'd4) begin
            bad++; $display("FAIL flush_resume valid=%b rd=%0d want 1 4", ex_valid_o, ex_rd_o);
        end
    endtask

    task automatic test_hold();
        hold_i = 1'b1;
        flush_i = 1'b1;
        id_addi(5'd2, 5'd1, 32'd5);
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (ex_valid_o !== 1'b1 || ex_rd_o !== 5'd4 || ex_funct_o !== 6'h20 || ex_imm_o !== 32'd0 ||
                stat_fl_o !== (STATS ? exp_fl : '0) || stat_lu_o !== (STATS ? exp_lu : '0)) begin
                bad++; $display("FAIL hold_cycle%0d valid=%b rd=%0d fl=%0d", i, ex_valid_o, ex_rd_o, stat_fl_o);
            end
        end
        hold_i = 1'b0;
        tick();
        exp_fl++;
        flush_i = 1'b0;
        total++;
        if (ex_valid_o !== 1'b0 || ex_rd_o !== 5'd0 || stat_fl_o !== (STATS ? exp_fl : '0)) begin
            bad++; $display("FAIL hold_release valid=%b rd=%0d fl=%0d", ex_valid_o, ex_rd_o, stat_fl_o);
        end
    endtask

    task automatic test_back_to_back();
        id_lw(1, 5'd3, 5'd1);
        tick();
        id_lw(1, 5'd5, 5'd3);
        #1;
        total++;
        if (stall_o !== 1'b1) begin bad++; $display("FAIL b2b_first_stall got=%b want=1", stall_o); end
        tick();
        exp_lu++;
        total++;
        if (stall_o !== 1'b0 || ex_valid_o !== 1'b0) begin
            bad++; $display("FAIL b2b_first_bubble stall=%b valid=%b", stall_o, ex_valid_o);
        end
        tick();
        id_add(5'd6, 5'd5, 5'd0);
        #1;
        total++;
        if (ex_rt_o !== 5'd5 || ex_mem_read_o !== 1'b1 || stall_o !== 1'b1) begin
            bad++; $display("FAIL b2b_second_stall rt=%0d mr=%b stall=%b", ex_rt_o, ex_mem_read_o, stall_o);
        end
        tick();
        exp_lu++;
        tick();
        total++;
        if (ex_rd_o !== 5'd6 || ex_valid_o !== 1'b1 || stall_o !== 1'b0 ||
            stat_lu_o !== (STATS ? exp_lu : '0)) begin
            bad++; $display("FAIL b2b_after rd=%0d valid=%b lu=%0d", ex_rd_o, ex_valid_o, stat_lu_o);
        end
    endtask

    task automatic test_reset_mid_stall();
        id_lw(1, 5'd3, 5'd1);
        tick();
        id_add(5'd4, 5'd3, 5'd5);
        #2;
        reset = 1'b1;
        #1;
        exp_lu = '0;
        exp_fl = '0;
        total++;
        if (stall_o !== 1'b0 || ex_valid_o !== 1'b0 || ex_mem_read_o !== 1'b0 || ex_rt_o !== 5'd0 ||
            stat_lu_o !== '0 || stat_fl_o !== '0) begin
            bad++; $display("FAIL reset_mid_stall stall=%b valid=%b mr=%b rt=%0d",
                            stall_o, ex_valid_o, ex_mem_read_o, ex_rt_o);
        end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_stats();
        int n;
        n = STATS ? 65537 : 4;
        id_addi(5'd2, 5'd1, 32'd5);
        flush_i = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick();
            if (exp_fl != '1) exp_fl++;
        end
        flush_i = 1'b0;
        total++;
        if (stat_fl_o !== (STATS ? exp_fl : '0) || stat_lu_o !== '0) begin
            bad++; $display("FAIL stats_sat fl=%h lu=%h want %h 0", stat_fl_o, stat_lu_o, STATS ? exp_fl : '0);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_specifiers();
        test_flush();
        test_hold();
        test_back_to_back();
        test_reset_mid_stall();
        test_stats();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
